// File: rtl/addn_seq.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per clock through one
// narrow adder slice, with valid/ready on both sides. ADDN_SUB_EN adds the sub port.
module addn_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef ADDN_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // RUN   | one slice added per edge, LSB slice first
    // DONE  | result held on outputs until out_ready
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [31:0]      bit_pos;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   slice_sum;
    logic             accept;
    logic             last_slice;

    // Operand conditioning at accept time: subtract is a + ~b + 1.
    always_comb begin
`ifdef ADDN_SUB_EN
        b_eff   = sub ? ~b : b;
        cin_eff = sub | carry_in;
`else
        b_eff   = b;
        cin_eff = carry_in;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        last_slice = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (idx == IDX_LAST) begin
                    last_slice = 1'b1;
                    state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Single narrow adder slice, selected by the running index.
    always_comb begin
        bit_pos   = {{(32-IDX_W){1'b0}}, idx} * 32'(CHUNK);
        a_slice   = a_q[bit_pos +: CHUNK];
        b_slice   = b_q[bit_pos +: CHUNK];
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
        acc_nxt   = acc;
        acc_nxt[bit_pos +: CHUNK] = slice_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
            acc       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_eff;
            carry_q <= cin_eff;
            idx     <= '0;
            acc     <= '0;
        end else if (state == ST_RUN) begin
            acc     <= acc_nxt;
            carry_q <= slice_sum[CHUNK];
            // Index wraps on the last slice so it never points past the operand.
            idx     <= last_slice ? '0 : idx + 1'b1;
            if (last_slice) begin
                sum       <= acc_nxt;
                carry_out <= slice_sum[CHUNK];
                overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_addn_seq.sv
// Randomized self-checking bench for addn_seq (WIDTH=16, CHUNK=4), compared
// against a whole-word arithmetic reference model.
module tb_addn_seq;

    localparam int W   = 16;
    localparam int CH  = 4;
    localparam int NCH = W / CH;
`ifdef ADDN_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
`ifdef ADDN_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    addn_seq #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
`ifdef ADDN_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {overflow, carry_out, sum} from plain whole-word arithmetic.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                              input logic rc, input logic rs);
        logic [W-1:0] bp;
        logic         c;
        logic [W:0]   full;
        logic         ovf;
        bp   = (rs && SUB_EN) ? ~rb : rb;
        c    = (rs && SUB_EN) ? 1'b1 : rc;
        full = {1'b0, ra} + {1'b0, bp} + {{W{1'b0}}, c};
        ovf  = (ra[W-1] == bp[W-1]) && (full[W-1] != ra[W-1]);
        return {ovf, full};
    endfunction

    task automatic drive_ops(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                             input logic tc, input logic ts);
        a        = ta;
        b        = tb_v;
        carry_in = tc;
`ifdef ADDN_SUB_EN
        sub      = ts;
`else
        if (ts) carry_in = tc;
`endif
    endtask

    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic tc, input logic ts, input int hold);
        logic [W+1:0] r;
        int lat;
        r = ref_add(ta, tb_v, tc, ts);
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd1);
        drive_ops(ta, tb_v, tc, ts);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive_ops(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        check("run_busy", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 3 * NCH) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(NCH));
        check("sum", 32'(sum), 32'(r[W-1:0]));
        check("carry_out", 32'(carry_out), 32'(r[W]));
        check("overflow", 32'(overflow), 32'(r[W+1]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            a        = W'($urandom);
            b        = W'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_sum", 32'(sum), 32'(r[W-1:0]));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("rel_valid", 32'(out_valid), 32'd0);
        check("rel_ready", 32'(in_ready), 32'd1);
        check("rel_sum", 32'(sum), 32'(r[W-1:0]));
    endtask

    task automatic back_to_back(input int n);
        logic [W+1:0] expq[$];
        logic [W+1:0] e;
        int accepts;
        int results;
        int last_acc;
        int cyc;
        accepts  = 0;
        results  = 0;
        last_acc = -1;
        cyc      = 0;
        drive_ops(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while ((accepts < n || expq.size() > 0) && cyc < n * (NCH + 2) + 20) begin
            @(negedge clk);
            if (out_valid) begin
                e = expq.pop_front();
                check("b2b_sum", 32'(sum), 32'(e[W-1:0]));
                check("b2b_flags", 32'({overflow, carry_out}), 32'(e[W+1:W]));
                results++;
            end
            if (in_ready && in_valid) begin
                if (accepts == n) begin
                    in_valid = 1'b0;
                end else begin
                    if (last_acc >= 0) check("b2b_interval", 32'(cyc - last_acc), 32'(NCH + 2));
                    expq.push_back(ref_add(a, b, carry_in, 1'b0));
                    last_acc = cyc;
                    accepts++;
                end
            end else begin
                drive_ops(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", 32'(results), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_ops('0, '0, 1'b0, 1'b0);
        #1;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_flags", 32'({overflow, carry_out}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_txn(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
        check("dir_00ff", 32'(sum), 32'h0100);
        run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        check("dir_ffff_c", 32'(carry_out), 32'd1);
        run_txn(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        check("dir_7fff_v", 32'(overflow), 32'd1);
        run_txn(16'h1234, 16'h4321, 1'b1, 1'b0, 5);

        for (int i = 0; i < 20; i++) begin
            run_txn(W'($urandom), W'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 3)));
        end

`ifdef ADDN_SUB_EN
        run_txn(16'd5, 16'd6, 1'b0, 1'b1, 0);
        run_txn(16'd100, 16'd100, 1'b0, 1'b1, 0);
        run_txn(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
        for (int i = 0; i < 10; i++) begin
            run_txn(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
        end
`endif

        // Abort a transaction one slice into RUN.
        @(negedge clk);
        drive_ops(16'h1234, 16'h1111, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NCH + 1) @(posedge clk);
        #1;
        check("abort_no_result", 32'(out_valid), 32'd0);
        run_txn(16'd5, 16'd65, 1'b0, 1'b0, 0);
        check("abort_next_sum", 32'(sum), 32'd70);

        back_to_back(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
